fpu_to_int_seq: RTL and testbench

- Downstream stage of the FPU datapath. Consumes one IEEE-754 single-precision result from the add/mul/div selector and converts it to a signed 32-bit two's-complement integer.
- Conversion truncates toward zero.
- The magnitude is aligned by an iterative shifter, one bit per cycle, to keep area small.
- Uses valid/ready handshakes on both sides. Flags overflow/saturation and invalid (NaN) inputs for the result formatter/display logic.

---
 rtl/fpu_to_int_seq.sv | 162 ++++++++++++++++
 tb/tb_fpu_to_int_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fpu_to_int_seq.sv
// Converts an IEEE-754 single to a signed 32-bit integer, truncating toward zero.
// The mantissa is aligned by a one-bit-per-cycle shifter behind valid/ready handshakes.
module fpu_to_int_seq #(
  parameter int BIAS  = 127,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;

  state_t            state_reg, state_next;
  logic              sign_reg, sign_next;
  logic [INT_W-1:0]  mag_reg, mag_next;
  logic [4:0]        cnt_reg, cnt_next;
  logic              dir_left_reg, dir_left_next;
  logic              special_reg, special_next;
  logic [INT_W-1:0]  special_val_reg, special_val_next;
  logic              ovf_pend_reg, ovf_pend_next;
  logic              nan_pend_reg, nan_pend_next;
  logic [INT_W-1:0]  out_data_reg, out_data_next;
  logic              out_ovf_reg, out_ovf_next;
  logic              out_nan_reg, out_nan_next;

  logic              in_sign;
  logic [7:0]        in_exp;
  logic [22:0]       in_frac;
  logic signed [9:0] unb_exp;
  logic [INT_W-1:0]  sat_val;

  assign in_sign = in_data[31];
  assign in_exp  = in_data[30:23];
  assign in_frac = in_data[22:0];
  assign unb_exp = signed'({2'b00, in_exp}) - 10'(BIAS);
  assign sat_val = in_sign ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};

  always_comb begin
    state_next       = state_reg;
    sign_next        = sign_reg;
    mag_next         = mag_reg;
    cnt_next         = cnt_reg;
    dir_left_next    = dir_left_reg;
    special_next     = special_reg;
    special_val_next = special_val_reg;
    ovf_pend_next    = ovf_pend_reg;
    nan_pend_next    = nan_pend_reg;
    out_data_next    = out_data_reg;
    out_ovf_next     = out_ovf_reg;
    out_nan_next     = out_nan_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next        = in_sign;
          mag_next         = {{(INT_W-24){1'b0}}, 1'b1, in_frac};
          cnt_next         = '0;
          special_next     = 1'b1;
          special_val_next = '0;
          ovf_pend_next    = 1'b0;
          nan_pend_next    = 1'b0;
          out_ovf_next     = 1'b0;
          out_nan_next     = 1'b0;
          state_next       = FINISH;
          if (in_exp == 8'hFF) begin
            if (in_frac != 23'd0) begin
              nan_pend_next = 1'b1;
            end else begin
              special_val_next = sat_val;
              ovf_pend_next    = 1'b1;
            end
          end else if (unb_exp < 10'sd0) begin
            special_val_next = '0;
          end else if (unb_exp >= 10'sd31) begin
            // -2^31 is the only value in this range that is exactly representable
            if (in_sign && unb_exp == 10'sd31 && in_frac == 23'd0) begin
              special_val_next = {1'b1, {(INT_W-1){1'b0}}};
            end else begin
              special_val_next = sat_val;
              ovf_pend_next    = 1'b1;
            end
          end else begin
            special_next = 1'b0;
            if (unb_exp <= 10'sd22) begin
              dir_left_next = 1'b0;
              cnt_next      = 5'(10'sd23 - unb_exp);
              state_next    = SHIFT;
            end else if (unb_exp > 10'sd23) begin
              dir_left_next = 1'b1;
              cnt_next      = 5'(unb_exp - 10'sd23);
              state_next    = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        mag_next = dir_left_reg ? (mag_reg << 1) : (mag_reg >> 1);
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        out_data_next = special_reg ? special_val_reg : (sign_reg ? (~mag_reg + 1'b1) : mag_reg);
        out_ovf_next  = ovf_pend_reg;
        out_nan_next  = nan_pend_reg;
        state_next    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      sign_reg        <= 1'b0;
      mag_reg         <= '0;
      cnt_reg         <= '0;
      dir_left_reg    <= 1'b0;
      special_reg     <= 1'b0;
      special_val_reg <= '0;
      ovf_pend_reg    <= 1'b0;
      nan_pend_reg    <= 1'b0;
      out_data_reg    <= '0;
      out_ovf_reg     <= 1'b0;
      out_nan_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sign_reg        <= sign_next;
      mag_reg         <= mag_next;
      cnt_reg         <= cnt_next;
      dir_left_reg    <= dir_left_next;
      special_reg     <= special_next;
      special_val_reg <= special_val_next;
      ovf_pend_reg    <= ovf_pend_next;
      nan_pend_reg    <= nan_pend_next;
      out_data_reg    <= out_data_next;
      out_ovf_reg     <= out_ovf_next;
      out_nan_reg     <= out_nan_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_nan   = out_nan_reg;

endmodule

// File: tb/tb_fpu_to_int_seq.sv
// Directed-vector bench for fpu_to_int_seq: result, flags and latency per conversion,
// plus backpressure and mid-conversion reset sequences.
module tb_fpu_to_int_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_nan;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fpu_to_int_seq #(.BIAS(127), .INT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_nan(out_nan)
  );

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        ovf;
    logic        nan;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present one float and return on the accept edge (+1ns).
  task automatic send(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int lat, bad_data, bad_rdy, bad_vld, seen;

    vecs[0]  = '{32'h40490FDB, 32'h00000003, 1'b0, 1'b0, 24};
    vecs[1]  = '{32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b0, 19};
    vecs[2]  = '{32'h3F000000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[3]  = '{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25};
    vecs[4]  = '{32'h4B000001, 32'h00800001, 1'b0, 1'b0, 2};
    vecs[5]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9};
    vecs[6]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    vecs[7]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 2};
    vecs[8]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 2};
    vecs[9]  = '{32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 2};
    vecs[10] = '{32'h80000000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[11] = '{32'hCF000001, 32'h80000000, 1'b1, 1'b0, 2};
    vecs[12] = '{32'h7F7FFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    vecs[13] = '{32'hC0000000, 32'hFFFFFFFE, 1'b0, 1'b0, 24};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst out_ovf", 32'(out_ovf), 32'd0);
    check("rst out_nan", 32'(out_nan), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].din);
      wait_valid(lat);
      $display("vec %0d: in=%h out=%h ovf=%b nan=%b lat=%0d", i, vecs[i].din, out_data, out_ovf, out_nan, lat);
      check($sformatf("v%0d data", i), out_data, vecs[i].dout);
      check($sformatf("v%0d ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d nan", i), 32'(out_nan), 32'(vecs[i].nan));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      consume();
    end

    // Backpressure: hold result for 10 cycles, ignore an input pulse meanwhile
    send(32'hC2F6E979);
    wait_valid(lat);
    held = out_data;
    check("bp first data", held, 32'hFFFFFF85);
    bad_data = 0; bad_rdy = 0; bad_vld = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
      end
      if (c == 5) in_valid = 1'b0;
      @(negedge clk);
      if (out_data !== held) bad_data++;
      if (in_ready !== 1'b0) bad_rdy++;
      if (out_valid !== 1'b1) bad_vld++;
    end
    $display("backpressure: held=%h bad_data=%0d bad_rdy=%0d bad_vld=%0d", held, bad_data, bad_rdy, bad_vld);
    check("bp data stable", 32'(bad_data), 32'd0);
    check("bp in_ready low", 32'(bad_rdy), 32'd0);
    check("bp out_valid held", 32'(bad_vld), 32'd0);
    consume();
    @(negedge clk);
    check("bp in_ready after", 32'(in_ready), 32'd1);
    check("bp out_valid after", 32'(out_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp no ghost accept", 32'(seen), 32'd0);

    // Reset mid-SHIFT on 1.0
    send(32'h3F800000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset mid-shift: in_ready=%b out_valid=%b out_data=%h", in_ready, out_valid, out_data);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid rst no result", 32'(seen), 32'd0);
    send(32'h40000000);
    wait_valid(lat);
    $display("after reset: in=40000000 out=%h ovf=%b nan=%b lat=%0d", out_data, out_ovf, out_nan, lat);
    check("post rst data", out_data, 32'h00000002);
    check("post rst flags", {30'd0, out_ovf, out_nan}, 32'd0);
    check("post rst latency", 32'(lat), 32'd24);
    consume();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
